// File: rtl/lcd_spi_tx.sv
// rtl/lcd_spi_tx.sv - display-side SPI mode-0 transmitter draining a first-word-fall-through FIFO
module lcd_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pull,
    output logic       sclk,
    output logic       mosi,
    output logic       dc,
    output logic       cs_n,
    output logic       busy
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          phase_end;
    logic          byte_end;

    assign phase_end = (div == DIV_LAST);
    // Last high phase of bit 0: the only point inside a frame where a new word may be taken.
    assign byte_end  = (state == SHIFT) && sclk && phase_end && (bit_cnt == 3'd7);
    assign fifo_pull = !rst && !fifo_empty && ((state == IDLE) || byte_end);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            dc      <= 1'b0;
            cs_n    <= 1'b1;
        end else if (fifo_pull) begin
            state   <= SHIFT;
            shreg   <= fifo_data[7:0];
            dc      <= fifo_data[8];
            mosi    <= fifo_data[7];
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            bit_cnt <= 3'd0;
            div     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                end
                SHIFT: begin
                    if (!phase_end) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_cnt != 3'd7) begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                            mosi    <= shreg[6];
                        end else begin
                            // FIFO ran dry at byte end: hold cs_n low one more phase.
                            state <= HOLD;
                            sclk  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!phase_end) begin
                        div <= div + 1'b1;
                    end else begin
                        div   <= '0;
                        state <= IDLE;
                        cs_n  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb/tb_lcd_spi_tx.sv - directed self-checking bench for lcd_spi_tx
module tb_lcd_spi_tx;
    logic clk;
    logic rst;

    logic [8:0] a_data, b_data;
    logic a_empty, a_pull, a_sclk, a_mosi, a_dc, a_cs_n, a_busy;
    logic b_empty, b_pull, b_sclk, b_mosi, b_dc, b_cs_n, b_busy;

    logic [8:0] a_mem [0:7];
    logic [8:0] b_mem [0:7];
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;

    int vectors = 0;
    int errs = 0;

    int          cap_pulls, cap_rises, cap_toggles, cap_windows, cap_win, cap_gap;
    int          cap_pull_at [4];
    logic [23:0] cap_bits, cap_dcs;

    lcd_spi_tx #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .fifo_data(a_data), .fifo_empty(a_empty), .fifo_pull(a_pull),
        .sclk(a_sclk), .mosi(a_mosi), .dc(a_dc), .cs_n(a_cs_n), .busy(a_busy)
    );

    lcd_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .fifo_data(b_data), .fifo_empty(b_empty), .fifo_pull(b_pull),
        .sclk(b_sclk), .mosi(b_mosi), .dc(b_dc), .cs_n(b_cs_n), .busy(b_busy)
    );

    // First-word-fall-through FIFO models: head visible while non-empty, popped on pull.
    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_data  = a_mem[a_rd % 8];
    assign b_data  = b_mem[b_rd % 8];

    always @(posedge clk) begin
        if (a_pull) a_rd <= a_rd + 1;
        if (b_pull) b_rd <= b_rd + 1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [8:0] w);
        if (sel) begin
            b_mem[b_wr % 8] = w;
            b_wr++;
        end else begin
            a_mem[a_wr % 8] = w;
            a_wr++;
        end
    endtask

    // Called at a negedge; samples 1 time unit after each of ncyc negedges.
    task automatic capture(input bit sel, input int ncyc, input int push_k, input logic [8:0] push_w);
        logic s, m, d, c, p, ps, pc, seen_low;
        int cur, gapcnt;
        cap_pulls = 0; cap_rises = 0; cap_toggles = 0; cap_windows = 0; cap_win = 0; cap_gap = 0;
        cap_bits = '0; cap_dcs = '0;
        for (int i = 0; i < 4; i++) cap_pull_at[i] = 0;
        ps = 1'b0; pc = 1'b1; seen_low = 1'b0; cur = 0; gapcnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (k == push_k) push(sel, push_w);
            #1;
            s = sel ? b_sclk : a_sclk;
            m = sel ? b_mosi : a_mosi;
            d = sel ? b_dc   : a_dc;
            c = sel ? b_cs_n : a_cs_n;
            p = sel ? b_pull : a_pull;
            if (p) begin
                if (cap_pulls < 4) cap_pull_at[cap_pulls] = k;
                cap_pulls++;
            end
            if (s && !ps) begin
                cap_bits = {cap_bits[22:0], m};
                cap_dcs  = {cap_dcs[22:0], d};
                cap_rises++;
            end
            if (s != ps) cap_toggles++;
            if (!c) begin
                if (pc) begin
                    cap_windows++;
                    cur = 0;
                    if (seen_low) cap_gap = gapcnt;
                end
                cur++;
                if (cur > cap_win) cap_win = cur;
                seen_low = 1'b1;
            end else begin
                if (!pc) gapcnt = 0;
                gapcnt++;
            end
            ps = s;
            pc = c;
            @(negedge clk);
        end
    endtask

    initial begin
        int rises;
        logic ps;
        rst = 1'b1;
        push(1'b0, {1'b0, 8'h2A});

        // Reset holds every output at its idle value even with a word waiting.
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_cs_n", 32'(a_cs_n), 1);
            chk("rst_sclk", 32'(a_sclk), 0);
            chk("rst_mosi", 32'(a_mosi), 0);
            chk("rst_dc",   32'(a_dc),   0);
            chk("rst_busy", 32'(a_busy), 0);
            chk("rst_pull", 32'(a_pull), 0);
            chk("rst_b_cs_n", 32'(b_cs_n), 1);
        end

        // Single byte, CLK_DIV=2.
        @(negedge clk);
        rst = 1'b0;
        capture(1'b0, 40, -1, 9'h0);
        chk("single_pulls",  cap_pulls, 1);
        chk("single_rises",  cap_rises, 8);
        chk("single_bits",   int'(cap_bits[7:0]), 'h2A);
        chk("single_dc",     int'(cap_dcs[7:0]), 0);
        chk("single_cs_low", cap_win, 34);
        chk("single_windows", cap_windows, 1);
        chk("single_idle",   32'(a_busy), 0);

        // Three words pre-queued stream under one chip-select window.
        push(1'b0, {1'b1, 8'hA5});
        push(1'b0, {1'b0, 8'h3C});
        push(1'b0, {1'b0, 8'hFF});
        capture(1'b0, 110, -1, 9'h0);
        chk("b2b_pulls",   cap_pulls, 3);
        chk("b2b_pull1",   cap_pull_at[1] - cap_pull_at[0], 32);
        chk("b2b_pull2",   cap_pull_at[2] - cap_pull_at[0], 64);
        chk("b2b_rises",   cap_rises, 24);
        chk("b2b_bits",    int'(cap_bits), 'hA53CFF);
        chk("b2b_dc",      int'(cap_dcs), 'hFF0000);
        chk("b2b_windows", cap_windows, 1);
        chk("b2b_cs_low",  cap_win, 98);

        // Word pushed during HOLD waits for IDLE; cs_n goes high for one cycle.
        push(1'b0, {1'b1, 8'hC3});
        capture(1'b0, 85, 33, {1'b0, 8'h5E});
        chk("late_pulls",   cap_pulls, 2);
        chk("late_pull1",   cap_pull_at[1] - cap_pull_at[0], 35);
        chk("late_rises",   cap_rises, 16);
        chk("late_bits",    int'(cap_bits[15:0]), 'hC35E);
        chk("late_dc",      int'(cap_dcs[15:0]), 'hFF00);
        chk("late_windows", cap_windows, 2);
        chk("late_gap",     cap_gap, 1);
        chk("late_cs_low",  cap_win, 34);

        // Asynchronous reset after the 4th sclk rise aborts the byte at once.
        push(1'b0, {1'b1, 8'h96});
        rises = 0;
        ps = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (a_sclk && !ps) rises++;
            ps = a_sclk;
            if (rises == 4) break;
            @(negedge clk);
        end
        chk("mid_rises", rises, 4);
        rst = 1'b1;
        #1;
        chk("mid_cs_n", 32'(a_cs_n), 1);
        chk("mid_sclk", 32'(a_sclk), 0);
        chk("mid_busy", 32'(a_busy), 0);
        chk("mid_pull", 32'(a_pull), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        capture(1'b0, 20, -1, 9'h0);
        chk("post_pulls",   cap_pulls, 0);
        chk("post_windows", cap_windows, 0);
        chk("post_busy",    32'(a_busy), 0);

        // CLK_DIV=1: sclk toggles every cycle, 17-cycle chip-select window.
        push(1'b1, {1'b1, 8'h81});
        capture(1'b1, 24, -1, 9'h0);
        chk("div1_pulls",   cap_pulls, 1);
        chk("div1_rises",   cap_rises, 8);
        chk("div1_toggles", cap_toggles, 16);
        chk("div1_bits",    int'(cap_bits[7:0]), 'h81);
        chk("div1_dc",      int'(cap_dcs[7:0]), 'hFF);
        chk("div1_cs_low",  cap_win, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
